// File: rtl/bingo_pkg.sv
// Shared state encoding, sizing constants and cell-index helpers for the bingo board engine.
package bingo_pkg;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_PLAY,
        ST_UPDATE,
        ST_DONE
    } state_e;

    localparam int unsigned N_DEFAULT = 5;
    localparam int unsigned LINES     = 2 * N_DEFAULT + 2;
    localparam int unsigned ACC_W     = 7;
    localparam int unsigned ACC_MAX   = 99;

    function automatic int unsigned num_lines(input int unsigned n);
        return 2 * n + 2;
    endfunction

    function automatic int unsigned row_cell(input int unsigned n, input int unsigned r,
                                             input int unsigned c);
        return r * n + c;
    endfunction

    function automatic int unsigned diag_cell(input int unsigned n, input int unsigned i);
        return i * n + i;
    endfunction

    function automatic int unsigned anti_cell(input int unsigned n, input int unsigned i);
        return i * n + (n - 1 - i);
    endfunction

endpackage

// File: rtl/bingo_board_n_line_eval.sv
// Combinational line detector: flags every complete row, column and diagonal and counts them.
module bingo_line_eval
    import bingo_pkg::*;
#(
    parameter int unsigned N = 5,
    localparam int unsigned CNT_W = $clog2(2 * N + 3)
) (
    input  logic [N*N-1:0]   circle,
    output logic [2*N+1:0]   line,
    output logic [CNT_W-1:0] line_cnt
);

    always_comb begin
        line = '1;
        for (int unsigned r = 0; r < N; r++) begin
            for (int unsigned c = 0; c < N; c++) begin
                line[r]     = line[r] & circle[row_cell(N, r, c)];
                line[N + r] = line[N + r] & circle[row_cell(N, c, r)];
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            line[2 * N]     = line[2 * N] & circle[diag_cell(N, i)];
            line[2 * N + 1] = line[2 * N + 1] & circle[anti_cell(N, i)];
        end
    end

    always_comb begin
        line_cnt = '0;
        for (int unsigned k = 0; k < 2 * N + 2; k++) begin
            line_cnt = line_cnt + CNT_W'(line[k]);
        end
    end

endmodule

// File: rtl/bingo_board_n.sv
// Single-player bingo board: keypad board entry, parallel number marking and registered line/win status.
module bingo_board_n
    import bingo_pkg::*;
#(
    parameter int unsigned N         = 5,
    parameter int unsigned VAL_W     = 5,
    parameter int unsigned WIN_LINES = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic [3:0]                  digit,
    input  logic                        digit_valid,
    input  logic                        enter_pulse,
    input  logic                        mark_valid,
    input  logic [VAL_W-1:0]            mark_num,
    output logic [N*N*VAL_W-1:0]        map,
    output logic [N*N-1:0]              circle,
    output logic [2*N+1:0]              line,
    output logic [$clog2(2*N+3)-1:0]    line_cnt,
    output logic                        filled,
    output logic                        win,
    output logic                        mark_ack,
    output logic                        mark_hit,
    output logic                        err
);

    localparam int unsigned CELLS = N * N;
    localparam int unsigned NL    = num_lines(N);
    localparam int unsigned CNT_W = $clog2(2 * N + 3);
    localparam int unsigned IDX_W = $clog2(CELLS + 1);

    state_e                 state_q, state_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [CELLS:1]         used_q, used_d;
    logic [IDX_W-1:0]       fill_idx_q, fill_idx_d;
    logic [CELLS*VAL_W-1:0] map_q, map_d;
    logic [CELLS-1:0]       circle_q, circle_d;
    logic [NL-1:0]          line_q, line_d;
    logic [CNT_W-1:0]       line_cnt_q, line_cnt_d;
    logic                   filled_q, filled_d;
    logic                   win_q, win_d;
    logic                   mark_ack_q, mark_ack_d;
    logic                   mark_hit_q, mark_hit_d;
    logic                   err_q, err_d;
    logic                   hit_pend_q, hit_pend_d;

    logic [9:0]             acc_mul;
    logic                   entry_in_range;
    logic                   entry_dup;
    logic [CELLS-1:0]       match_vec;
    logic [NL-1:0]          line_w;
    logic [CNT_W-1:0]       line_cnt_w;

    bingo_line_eval #(
        .N(N)
    ) u_line_eval (
        .circle   (circle_q),
        .line     (line_w),
        .line_cnt (line_cnt_w)
    );

    assign acc_mul        = 10'(acc_q) * 10'd10 + 10'(digit);
    assign entry_in_range = (acc_q != '0) && (acc_q <= ACC_W'(CELLS));

    always_comb begin
        entry_dup = 1'b0;
        for (int unsigned v = 1; v <= CELLS; v++) begin
            if (acc_q == ACC_W'(v)) entry_dup = used_q[v];
        end
    end

    // Values are unique once the board is full, so at most one comparator fires.
    always_comb begin
        match_vec = '0;
        for (int unsigned k = 0; k < CELLS; k++) begin
            match_vec[k] = (map_q[k*VAL_W +: VAL_W] == mark_num);
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        used_d     = used_q;
        fill_idx_d = fill_idx_q;
        map_d      = map_q;
        circle_d   = circle_q;
        line_d     = line_q;
        line_cnt_d = line_cnt_q;
        filled_d   = filled_q;
        win_d      = win_q;
        hit_pend_d = hit_pend_q;
        mark_ack_d = 1'b0;
        mark_hit_d = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            ST_FILL: begin
                if (enter_pulse) begin
                    acc_d = '0;
                    if (entry_in_range && !entry_dup) begin
                        for (int unsigned k = 0; k < CELLS; k++) begin
                            if (fill_idx_q == IDX_W'(k)) map_d[k*VAL_W +: VAL_W] = VAL_W'(acc_q);
                        end
                        for (int unsigned v = 1; v <= CELLS; v++) begin
                            if (acc_q == ACC_W'(v)) used_d[v] = 1'b1;
                        end
                        fill_idx_d = fill_idx_q + IDX_W'(1);
                        if (fill_idx_q == IDX_W'(CELLS - 1)) begin
                            filled_d = 1'b1;
                            state_d  = ST_PLAY;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (digit_valid) begin
                    if (digit <= 4'd9) begin
                        acc_d = (acc_mul > 10'(ACC_MAX)) ? ACC_W'(ACC_MAX) : acc_mul[ACC_W-1:0];
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (mark_valid) err_d = 1'b1;
            end

            ST_PLAY: begin
                if (mark_valid) begin
                    circle_d   = circle_q | match_vec;
                    hit_pend_d = |match_vec;
                    state_d    = ST_UPDATE;
                end
            end

            // circle_q already holds the new mark here, so the evaluator output is current.
            ST_UPDATE: begin
                line_d     = line_w;
                line_cnt_d = line_cnt_w;
                win_d      = (line_cnt_w >= CNT_W'(WIN_LINES));
                mark_ack_d = 1'b1;
                mark_hit_d = hit_pend_q;
                state_d    = (line_cnt_w >= CNT_W'(WIN_LINES)) ? ST_DONE : ST_PLAY;
                if (mark_valid) err_d = 1'b1;
            end

            ST_DONE: begin
                if (mark_valid) err_d = 1'b1;
            end

            default: state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q    <= ST_FILL;
            acc_q      <= '0;
            used_q     <= '0;
            fill_idx_q <= '0;
            map_q      <= '0;
            circle_q   <= '0;
            line_q     <= '0;
            line_cnt_q <= '0;
            filled_q   <= 1'b0;
            win_q      <= 1'b0;
            hit_pend_q <= 1'b0;
            mark_ack_q <= 1'b0;
            mark_hit_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            used_q     <= used_d;
            fill_idx_q <= fill_idx_d;
            map_q      <= map_d;
            circle_q   <= circle_d;
            line_q     <= line_d;
            line_cnt_q <= line_cnt_d;
            filled_q   <= filled_d;
            win_q      <= win_d;
            hit_pend_q <= hit_pend_d;
            mark_ack_q <= mark_ack_d;
            mark_hit_q <= mark_hit_d;
            err_q      <= err_d;
        end
    end

    assign map      = map_q;
    assign circle   = circle_q;
    assign line     = line_q;
    assign line_cnt = line_cnt_q;
    assign filled   = filled_q;
    assign win      = win_q;
    assign mark_ack = mark_ack_q;
    assign mark_hit = mark_hit_q;
    assign err      = err_q;

endmodule

// File: tb/tb_bingo_board_n.sv
// Directed bench for bingo_board_n: a 5x5 board and a 3x3 single-line-win board side by side.
module tb_bingo_board_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst5, clr5, dv5, ent5, mv5;
    logic [3:0]   dg5;
    logic [4:0]   mn5;
    logic [124:0] map5;
    logic [24:0]  circ5;
    logic [11:0]  line5;
    logic [3:0]   cnt5;
    logic         filled5, win5, ack5, hit5, err5;

    logic         rst3, clr3, dv3, ent3, mv3;
    logic [3:0]   dg3;
    logic [3:0]   mn3;
    logic [35:0]  map3;
    logic [8:0]   circ3;
    logic [7:0]   line3;
    logic [3:0]   cnt3;
    logic         filled3, win3, ack3, hit3, err3;

    bingo_board_n #(.N(5), .VAL_W(5), .WIN_LINES(5)) u5 (
        .clk(clk), .rst(rst5), .clear(clr5), .digit(dg5), .digit_valid(dv5),
        .enter_pulse(ent5), .mark_valid(mv5), .mark_num(mn5), .map(map5),
        .circle(circ5), .line(line5), .line_cnt(cnt5), .filled(filled5),
        .win(win5), .mark_ack(ack5), .mark_hit(hit5), .err(err5)
    );

    bingo_board_n #(.N(3), .VAL_W(4), .WIN_LINES(1)) u3 (
        .clk(clk), .rst(rst3), .clear(clr3), .digit(dg3), .digit_valid(dv3),
        .enter_pulse(ent3), .mark_valid(mv3), .mark_num(mn3), .map(map3),
        .circle(circ3), .line(line3), .line_cnt(cnt3), .filled(filled3),
        .win(win3), .mark_ack(ack3), .mark_hit(hit3), .err(err3)
    );

    int checks = 0;
    int errors = 0;
    int err5_cnt = 0;
    int err3_cnt = 0;
    int ack3_cnt = 0;
    logic exp_hit5 [$];
    logic exp_hit3 [$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every mark_ack pops the hit value queued when the mark was driven.
    always @(negedge clk) begin
        if (err5) err5_cnt++;
        if (ack5) begin
            checks++;
            assert (exp_hit5.size() != 0) else begin
                errors++;
                $error("FAIL ack5_expected observed=ack expected=no_ack");
            end
            if (exp_hit5.size() != 0) chk("mark_hit5", 128'(hit5), 128'(exp_hit5.pop_front()));
        end
        if (err3) err3_cnt++;
        if (ack3) begin
            ack3_cnt++;
            checks++;
            assert (exp_hit3.size() != 0) else begin
                errors++;
                $error("FAIL ack3_expected observed=ack expected=no_ack");
            end
            if (exp_hit3.size() != 0) chk("mark_hit3", 128'(hit3), 128'(exp_hit3.pop_front()));
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic key5(input logic [3:0] d);
        dg5 = d; dv5 = 1'b1; tick(); dv5 = 1'b0;
    endtask

    task automatic enter5(input int unsigned v);
        if (v >= 10) key5(4'(v / 10));
        key5(4'(v % 10));
        ent5 = 1'b1; tick(); ent5 = 1'b0;
    endtask

    task automatic enter3(input int unsigned v);
        dg3 = 4'(v); dv3 = 1'b1; tick(); dv3 = 1'b0;
        ent3 = 1'b1; tick(); ent3 = 1'b0;
    endtask

    task automatic drain5;
        for (int i = 0; i < 6; i++) if (exp_hit5.size() != 0) tick();
        chk("ack5_timeout", 128'(exp_hit5.size()), 128'(0));
        exp_hit5.delete();
    endtask

    task automatic drain3;
        for (int i = 0; i < 6; i++) if (exp_hit3.size() != 0) tick();
        chk("ack3_timeout", 128'(exp_hit3.size()), 128'(0));
        exp_hit3.delete();
    endtask

    function automatic logic on_board5(input int unsigned v);
        return (v >= 1) && (v <= 25);
    endfunction

    task automatic mark5(input int unsigned v);
        mn5 = 5'(v); mv5 = 1'b1; exp_hit5.push_back(on_board5(v)); tick(); mv5 = 1'b0;
        drain5();
    endtask

    task automatic mark3(input int unsigned v);
        mn3 = 4'(v); mv3 = 1'b1; exp_hit3.push_back((v >= 1) && (v <= 9)); tick(); mv3 = 1'b0;
        drain3();
    endtask

    initial begin
        logic [124:0] exp_map5;
        logic [24:0]  circ_save;
        int e0;
        int a0;

        {rst5, clr5, dv5, ent5, mv5} = '0; dg5 = '0; mn5 = '0;
        {rst3, clr3, dv3, ent3, mv3} = '0; dg3 = '0; mn3 = '0;

        rst5 = 1'b1; rst3 = 1'b1; tick(); tick(); rst5 = 1'b0; rst3 = 1'b0;
        chk("rst_map5", 128'(map5), 128'(0));
        chk("rst_circle5", 128'(circ5), 128'(0));
        chk("rst_line5", 128'(line5), 128'(0));
        chk("rst_cnt5", 128'(cnt5), 128'(0));
        chk("rst_flags5", 128'({filled5, win5, ack5, hit5, err5}), 128'(0));
        chk("rst_flags3", 128'({filled3, win3, ack3, hit3, err3}), 128'(0));

        // Fill the 5x5 board row-major, with rejected entries interleaved.
        for (int unsigned v = 1; v <= 7; v++) enter5(v);
        e0 = err5_cnt; enter5(7); tick();
        chk("dup7_err", 128'(err5_cnt - e0), 128'(1));
        e0 = err5_cnt; enter5(0); tick();
        chk("zero_err", 128'(err5_cnt - e0), 128'(1));
        e0 = err5_cnt; enter5(26); tick();
        chk("over_err", 128'(err5_cnt - e0), 128'(1));
        e0 = err5_cnt; key5(4'd12); tick();
        chk("bad_digit_err", 128'(err5_cnt - e0), 128'(1));
        key5(4'd8); ent5 = 1'b1; tick(); ent5 = 1'b0;
        chk("cell7_after_rejects", 128'(map5[7*5 +: 5]), 128'(8));
        e0 = err5_cnt; mn5 = 5'd1; mv5 = 1'b1; tick(); mv5 = 1'b0; tick();
        chk("mark_in_fill_err", 128'(err5_cnt - e0), 128'(1));
        chk("mark_in_fill_circle", 128'(circ5), 128'(0));

        e0 = err5_cnt;
        key5(4'd9);
        dg5 = 4'd5; dv5 = 1'b1; ent5 = 1'b1; tick(); dv5 = 1'b0; ent5 = 1'b0;
        enter5(10);
        chk("cell8_enter_wins", 128'(map5[8*5 +: 5]), 128'(9));
        chk("cell9_digit_dropped", 128'(map5[9*5 +: 5]), 128'(10));
        for (int unsigned v = 11; v <= 24; v++) enter5(v);
        chk("filled5_before_last", 128'(filled5), 128'(0));
        enter5(25);
        chk("filled5_after_last", 128'(filled5), 128'(1));
        chk("cell24", 128'(map5[24*5 +: 5]), 128'(25));
        for (int unsigned k = 0; k < 25; k++) exp_map5[k*5 +: 5] = 5'(k + 1);
        chk("map5_full", 128'(map5), 128'(exp_map5));
        tick();
        chk("no_err_clean_fill", 128'(err5_cnt - e0), 128'(0));

        // Marking on the row-major board.
        for (int unsigned v = 1; v <= 4; v++) mark5(v);
        chk("cnt5_row0_partial", 128'(cnt5), 128'(0));
        mark5(5);
        chk("line5_row0", 128'(line5), 128'h001);
        chk("cnt5_row0", 128'(cnt5), 128'(1));
        chk("win5_row0", 128'(win5), 128'(0));
        mark5(3);
        chk("cnt5_remark", 128'(cnt5), 128'(1));
        chk("circle5_remark", 128'(circ5), 128'h1F);
        mark5(30);
        chk("circle5_absent", 128'(circ5), 128'h1F);

        e0 = err5_cnt;
        mn5 = 5'd6; mv5 = 1'b1; exp_hit5.push_back(1'b1); tick();
        mn5 = 5'd7; tick(); mv5 = 1'b0;
        drain5(); tick();
        chk("back_to_back_err", 128'(err5_cnt - e0), 128'(1));
        chk("back_to_back_dropped", 128'(circ5), 128'h3F);

        for (int unsigned v = 7; v <= 20; v++) mark5(v);
        chk("cnt5_rows0_3", 128'(cnt5), 128'(4));
        chk("win5_rows0_3", 128'(win5), 128'(0));
        mark5(25);
        chk("line5_win", 128'(line5), 128'h60F);
        chk("cnt5_win", 128'(cnt5), 128'(6));
        chk("win5", 128'(win5), 128'(1));
        chk("circle5_win", 128'(circ5), 128'h10FFFFF);

        circ_save = circ5;
        e0 = err5_cnt;
        mn5 = 5'd21; mv5 = 1'b1; tick(); mv5 = 1'b0; tick(); tick();
        chk("done_mark_err", 128'(err5_cnt - e0), 128'(1));
        chk("done_circle_hold", 128'(circ5), 128'(circ_save));
        chk("done_win_hold", 128'(win5), 128'(1));

        // 3x3 board: clear during UPDATE, then refill and win on the anti-diagonal.
        for (int unsigned v = 1; v <= 9; v++) enter3(v);
        chk("filled3_first", 128'(filled3), 128'(1));
        a0 = ack3_cnt;
        mn3 = 4'd1; mv3 = 1'b1; tick(); mv3 = 1'b0;
        clr3 = 1'b1; tick(); clr3 = 1'b0;
        chk("clear_map3", 128'(map3), 128'(0));
        chk("clear_circle3", 128'(circ3), 128'(0));
        chk("clear_line3", 128'({line3, cnt3}), 128'(0));
        chk("clear_flags3", 128'({filled3, win3, ack3, hit3, err3}), 128'(0));
        tick(); tick();
        chk("clear_no_ack3", 128'(ack3_cnt - a0), 128'(0));

        for (int unsigned v = 1; v <= 9; v++) enter3(v);
        chk("filled3_refill", 128'(filled3), 128'(1));
        chk("map3_refill", 128'(map3), 128'h987654321);
        mark3(3);
        mark3(5);
        chk("win3_partial", 128'(win3), 128'(0));
        mark3(7);
        chk("line3_anti", 128'(line3), 128'h80);
        chk("cnt3_anti", 128'(cnt3), 128'(1));
        chk("win3", 128'(win3), 128'(1));
        chk("circle3", 128'(circ3), 128'h54);
        chk("err3_total", 128'(err3_cnt), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bingo_board_n.md
# bingo_board_n

Parametrised Bingo board engine for one player: an N×N board with values 1..N·N. It captures player entry of the board from decimal keypad digits, then marks called numbers and keeps a registered status of circles, completed lines, line count and win. It sits under the game master FSM, which drives digit and enter pulses during selection and forwards guessed numbers from either board. Its outputs feed the display and the inter-board link.

## Interface
Parameters:
- N, 5: board dimension; N·N cells, 2N+2 candidate lines.
- VAL_W, 5: cell value width; must satisfy 2^VAL_W > N·N.
- WIN_LINES, 5: number of completed lines that declares a win; range 1..2N+2.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- clear  in  1  synchronous board restart; same effect as rst.
- digit  in  4  keypad digit 0..9.
- digit_valid  in  1  single-cycle pulse; appends digit to the entry accumulator.
- enter_pulse  in  1  single-cycle pulse; commits the accumulator to the next cell.
- mark_valid  in  1  single-cycle pulse; requests a mark of mark_num.
- mark_num  in  VAL_W  called number.
- map  out  N·N·VAL_W  cell k = row·N+col is at map[k·VAL_W +: VAL_W].
- circle  out  N·N  bit k set means cell k is marked.
- line  out  2N+2  bits [N-1:0] are rows; [2N-1:N] are columns; [2N] is the main diagonal; [2N+1] is the anti-diagonal.
- line_cnt  out  $clog2(2N+3)  population count of line.
- filled  out  1  level; board fully entered.
- win  out  1  level; line_cnt ≥ WIN_LINES.
- mark_ack  out  1  single-cycle pulse; a mark request has completed.
- mark_hit  out  1  valid with mark_ack; the number is on the board.
- err  out  1  single-cycle pulse; the input was rejected.

## Operation
States: FILL, PLAY, UPDATE, DONE. Reset or clear goes to FILL.

FILL:
- digit_valid with digit ≤ 9: acc ← min(acc·10+digit, 99). acc is 7 bits.
- digit_valid with digit > 9: err pulse; acc is unchanged.
- enter_pulse: let v = acc. If 1 ≤ v ≤ N·N and used[v] = 0:
  - write v to cell fill_idx.
  - set used[v].
  - increment fill_idx.
- enter_pulse with v outside 1..N·N, or v already used: err pulse; nothing is written.
- acc is cleared on every enter_pulse, whether or not the entry is accepted.
- enter_pulse and digit_valid in the same cycle: enter wins and the digit is dropped.
- Accepting the N·N-th entry sets filled and moves to PLAY.
- mark_valid in FILL: err pulse; the request is ignored.

PLAY:
- mark_valid compares mark_num against all cells in parallel. The matching cell's circle bit is set; there is at most one match because values are unique.
- Next state is UPDATE.
- Marking an already-circled number gives hit = 1 with no state change.
- A number absent from the board gives hit = 0.

UPDATE:
- line and line_cnt are registered from the new circle.
- mark_ack and mark_hit pulse.
- If win, go to DONE; otherwise go to PLAY.
- mark_valid arriving in UPDATE is dropped with an err pulse.

DONE:
- All outputs hold.
- mark_valid gives an err pulse.
- Only rst or clear exits.

## Timing
- Reset/clear values:
  - map, circle, line, used, acc, fill_idx, line_cnt = 0.
  - filled, win, mark_ack, mark_hit, err = 0.
- Entry: the map cell and filled update on the clock edge that samples enter_pulse; they are visible the next cycle.
- Mark latency: with mark_valid sampled at edge t:
  - circle updates at t.
  - line, line_cnt, win, mark_ack and mark_hit are valid after edge t+1.
  - Throughput is one mark per 2 cycles.
- err is asserted the cycle after the offending input.
- clear or rst asserted during UPDATE aborts the update; no mark_ack is issued.
- clear and rst have priority over every other input in the same cycle.

## Structure
- Package bingo_pkg holds:
  - the state enum.
  - LINES = 2N+2.
  - index functions row_cell(r,c), diag_cell(i), anti_cell(i).
- One sub-module, bingo_line_eval: combinational, parametrised by N. It takes circle and produces line and the popcount; the top level registers both.
- Top level holds the FSM, entry accumulator, used bitmap and comparators.

## Test plan
- N=5: enter 1..25 in row-major order via two-digit sequences → filled = 1 after the 25th enter; map cell 24 = 25; err never pulses.
- N=5 fill: enter 7 twice → err pulses on the second enter and fill_idx stays at 7. Enter 0 and 26 → err on each.
- Mark 1,2,3,4,5 on the row-major board → line[0] = 1 and line_cnt = 1 two cycles after the 5th mark_valid. Re-mark 3 → mark_hit = 1 and line_cnt stays 1.
- Complete rows 0–3 and the main diagonal (WIN_LINES = 5) → win = 1 and state DONE. A further mark_valid → err, with circle unchanged.
- mark_valid on the cycle after a mark → err and the request is dropped. Mark 30 on N=5 with VAL_W=5 → mark_ack with mark_hit = 0.
- N=3, VAL_W=4, WIN_LINES=1: assert clear mid-UPDATE → all outputs 0 the next cycle and no mark_ack. Refill, then mark 3,5,7 → line[7] (anti-diagonal) = 1 and win = 1.
